ldm_register_writer: RTL and testbench

- Sequences an ARM load-multiple (LDM, increment-after) into the 16-entry register file through its single write port (A3/WD3/WE3).
- Issues one word address per register, accepts memory data over a valid/ready handshake, and writes registers in ascending index order.
- R15 is not writable through the register file, so an R15 load is redirected to a PC-load output.
- Sits between the data-memory port and the register-file write port.

---
 rtl/ldm_pkg.sv | 19 +
 rtl/priority_encoder_16.sv | 26 ++
 rtl/ldm_register_writer.sv | 199 +++++++++++++++++++
 tb/tb_ldm_register_writer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_pkg.sv
// ldm_pkg
//   Shared definitions for the LDM register writer: FSM state encoding,
//   default data/address width, address step per transferred register and
//   the index of the program counter (R15), which never goes through the
//   register-file write port.
package ldm_pkg;

    localparam int         W_DEFAULT  = 32;
    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_INDEX   = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/priority_encoder_16.sv
// priority_encoder_16
//   Combinational lowest-set-bit finder for a 16-bit vector.
//   Ports:
//     vec_i  [15:0]  input vector
//     idx_o  [3:0]   index of the lowest set bit (0 when vec_i is zero)
//     none_o         high when vec_i has no bit set
module priority_encoder_16
    import ldm_pkg::*;
(
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        none_o
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx_o = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 4'(i);
            end
        end
        none_o = (vec_i == 16'd0);
    end

endmodule

// File: rtl/ldm_register_writer.sv
// ldm_register_writer
//   Sequences an LDM (increment-after) into the register file's single write
//   port. One word address is issued per listed register, data is accepted on
//   MemValid & MemReady, and registers are written in ascending index order,
//   one cycle after each transfer. A load of R15 is redirected to PCWrite/PCData.
//
//   Build option: LDM_WRITEBACK_EN adds a one-cycle WB state that writes
//   BaseAddr + WORD_BYTES*count back to Rn, unless Rn is in the list or is R15.
//   Without it, LOAD goes straight to DONE and Rn is ignored.
//
//   Ports:
//     CLK, RESET (sync, active low)
//     Start, RegList, Rn, BaseAddr         request, latched in IDLE
//     MemAddr, MemReady, MemData, MemValid data-memory side
//     A3, WD3, WE3                         register-file write port
//     PCWrite, PCData                      R15 load redirect
//     Busy, Done                           status
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for Start
//   S_LOAD | requesting words, one per remaining register in the list
//   S_WB   | single-cycle base writeback (LDM_WRITEBACK_EN only)
//   S_DONE | one-cycle completion pulse, then back to S_IDLE
module ldm_register_writer
    import ldm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         Start,
    input  logic [15:0]  RegList,
    input  logic [3:0]   Rn,
    input  logic [W-1:0] BaseAddr,
    output logic [W-1:0] MemAddr,
    output logic         MemReady,
    input  logic [W-1:0] MemData,
    input  logic         MemValid,
    output logic [3:0]   A3,
    output logic [W-1:0] WD3,
    output logic         WE3,
    output logic         PCWrite,
    output logic [W-1:0] PCData,
    output logic         Busy,
    output logic         Done
);

    state_t       state_q, state_d;
    logic [15:0]  list_q,  list_d;
    logic [W-1:0] addr_q,  addr_d;
    logic [4:0]   count_q, count_d;
    logic         we3_q,   we3_d;
    logic [3:0]   a3_q,    a3_d;
    logic [W-1:0] wd3_q,   wd3_d;
    logic         pcw_q,   pcw_d;
    logic [W-1:0] pcd_q,   pcd_d;

`ifdef LDM_WRITEBACK_EN
    // The working list is consumed during LOAD, so keep the original for the
    // "Rn is in the list" test.
    logic [15:0]  orig_q,  orig_d;
    logic [3:0]   rn_q,    rn_d;
    logic [W-1:0] base_q,  base_d;
`else
    logic         unused_wb_inputs;
    assign unused_wb_inputs = ^{Rn, count_q};
`endif

    logic [3:0]   idx;
    logic         none;
    logic [15:0]  list_clr;

    priority_encoder_16 u_penc (
        .vec_i  (list_q),
        .idx_o  (idx),
        .none_o (none)
    );

    assign list_clr = list_q & ~(16'd1 << idx);

    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        addr_d  = addr_q;
        count_d = count_q;
        we3_d   = 1'b0;
        a3_d    = 4'd0;
        wd3_d   = '0;
        pcw_d   = 1'b0;
        pcd_d   = '0;
`ifdef LDM_WRITEBACK_EN
        orig_d  = orig_q;
        rn_d    = rn_q;
        base_d  = base_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (RegList != 16'd0) begin
                        list_d  = RegList;
                        addr_d  = BaseAddr;
                        count_d = 5'd0;
`ifdef LDM_WRITEBACK_EN
                        orig_d  = RegList;
                        rn_d    = Rn;
                        base_d  = BaseAddr;
`endif
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (none) begin
                    state_d = S_DONE;
                end else if (MemValid) begin
                    list_d  = list_clr;
                    addr_d  = addr_q + W'(WORD_BYTES);
                    count_d = count_q + 5'd1;
                    if (idx == PC_INDEX) begin
                        pcw_d = 1'b1;
                        pcd_d = MemData;
                    end else begin
                        we3_d = 1'b1;
                        a3_d  = idx;
                        wd3_d = MemData;
                    end
                    if (list_clr == 16'd0) begin
`ifdef LDM_WRITEBACK_EN
                        state_d = S_WB;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_WB: begin
`ifdef LDM_WRITEBACK_EN
                // A loaded Rn keeps the loaded value.
                if (!orig_q[rn_q] && (rn_q != PC_INDEX)) begin
                    we3_d = 1'b1;
                    a3_d  = rn_q;
                    wd3_d = base_q + W'(WORD_BYTES) * W'(count_q);
                end
`endif
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            list_q  <= 16'd0;
            addr_q  <= '0;
            count_q <= 5'd0;
            we3_q   <= 1'b0;
            a3_q    <= 4'd0;
            wd3_q   <= '0;
            pcw_q   <= 1'b0;
            pcd_q   <= '0;
`ifdef LDM_WRITEBACK_EN
            orig_q  <= 16'd0;
            rn_q    <= 4'd0;
            base_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            pcw_q   <= pcw_d;
            pcd_q   <= pcd_d;
`ifdef LDM_WRITEBACK_EN
            orig_q  <= orig_d;
            rn_q    <= rn_d;
            base_q  <= base_d;
`endif
        end
    end

    assign MemAddr  = addr_q;
    assign MemReady = (state_q == S_LOAD);
    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign WE3      = we3_q;
    assign PCWrite  = pcw_q;
    assign PCData   = pcd_q;
    assign Busy     = (state_q == S_LOAD) || (state_q == S_WB);
    assign Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ldm_register_writer.sv
module tb_ldm_register_writer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] RegList = 16'd0;
    logic [3:0]  Rn = 4'd0;
    logic [31:0] BaseAddr = 32'd0;
    logic [31:0] MemAddr;
    logic        MemReady;
    logic [31:0] MemData = 32'd0;
    logic        MemValid = 1'b0;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        PCWrite;
    logic [31:0] PCData;
    logic        Busy;
    logic        Done;

    always #5 CLK = ~CLK;

    ldm_register_writer #(.W(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .RegList  (RegList),
        .Rn       (Rn),
        .BaseAddr (BaseAddr),
        .MemAddr  (MemAddr),
        .MemReady (MemReady),
        .MemData  (MemData),
        .MemValid (MemValid),
        .A3       (A3),
        .WD3      (WD3),
        .WE3      (WE3),
        .PCWrite  (PCWrite),
        .PCData   (PCData),
        .Busy     (Busy),
        .Done     (Done)
    );

    // kind: 0 = register write, 1 = PC write, 2 = done pulse
    typedef struct {
        int          kind;
        logic [3:0]  a;
        logic [31:0] d;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] addr_exp[$];
    logic [31:0] words [16];
    int          tests = 0;
    int          fails = 0;
    bit          done_seen = 1'b0;
    logic        prev_done = 1'b0;

    function automatic ev_t mk(input int kind, input logic [3:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input int kind, input logic [3:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got event kind=%0d a=%0d d=%0h, expected no event", name, kind, a, d);
        end else begin
            e = exp_q.pop_front();
            check(name, {8'(kind), a, d}, {8'(e.kind), e.a, e.d});
        end
    endtask

    // Reference: one transfer per set bit in ascending order, each word at
    // base + 4*k; R15 goes to the PC; optional writeback of the final address.
    task automatic model_push(input logic [15:0] list, input logic [3:0] rn, input logic [31:0] base);
        int cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                addr_exp.push_back(base + 32'(4 * cnt));
                if (i == 15) exp_q.push_back(mk(1, 4'd0, words[cnt]));
                else         exp_q.push_back(mk(0, 4'(i), words[cnt]));
                cnt++;
            end
        end
`ifdef LDM_WRITEBACK_EN
        if (cnt > 0 && !list[rn] && rn != 4'd15)
            exp_q.push_back(mk(0, rn, base + 32'(4 * cnt)));
`else
        if (rn == 4'd0) cnt = 0;
`endif
        exp_q.push_back(mk(2, 4'd0, 32'd0));
    endtask

    // Monitor: consumes expected events whenever the DUT presents one.
    always @(negedge CLK) begin : monitor
        if (RESET) begin
            if (WE3 || PCWrite) check("we3_pcwrite_exclusive", WE3 & PCWrite, 0);
            if (MemReady && MemValid) begin
                if (addr_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer: got MemAddr=%0h, expected no transfer", MemAddr);
                end else begin
                    check("mem_addr", MemAddr, addr_exp.pop_front());
                end
            end
            if (WE3)     pop_cmp("reg_write", 0, A3, WD3);
            if (PCWrite) pop_cmp("pc_write", 1, 4'd0, PCData);
            if (Done) begin
                pop_cmp("done", 2, 4'd0, 32'd0);
                check("busy_low_in_done", Busy, 0);
                check("done_single_cycle", prev_done, 0);
                done_seen = 1'b1;
            end
            if (MemReady) check("busy_in_load", Busy, 1);
            prev_done = Done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic fill_words();
        for (int i = 0; i < 16; i++) words[i] = $urandom;
    endtask

    task automatic run_op(input logic [15:0] list, input logic [3:0] rn, input logic [31:0] base,
                          input int stall, input bit always_v, input int abort_after, input bit noise);
        int n = 0;
        int k = 0;
        bit planned = 1'b0;
        bit aborted = 1'b0;
        for (int i = 0; i < 16; i++) if (list[i]) n++;
        model_push(list, rn, base);
        done_seen = 1'b0;
        @(posedge CLK); #1;
        Start = 1'b1; RegList = list; Rn = rn; BaseAddr = base; MemValid = 1'b0;
        for (int c = 0; c < 300 && !done_seen && !aborted; c++) begin
            @(posedge CLK); #1;
            if (planned) k++;
            Start = 1'b0;
            if (list == 16'd0 && c == 0) begin
                check("empty_done_next_cycle", Done, 1);
                check("empty_no_ready", MemReady, 0);
            end
            if (c < stall) begin
                check("stall_addr_hold", MemAddr, base);
                check("stall_no_we3", WE3, 0);
            end
            if (abort_after > 0 && k == abort_after) begin
                MemValid = 1'b0;
                @(negedge CLK); #1;
                RESET = 1'b0;
                @(posedge CLK); #1;
                check("abort_outputs_zero",
                      {MemAddr, MemReady, A3, WD3, WE3, PCWrite, PCData, Busy, Done}, 0);
                exp_q.delete();
                addr_exp.delete();
                @(posedge CLK); #1;
                RESET = 1'b1;
                aborted = 1'b1;
            end else begin
                MemValid = (k < n) && (c >= stall) && (always_v || $urandom_range(0, 2) != 0);
                MemData  = (k < n) ? words[k] : $urandom;
                planned  = MemValid && MemReady;
                if (noise && MemReady && $urandom_range(0, 7) == 0) begin
                    Start = 1'b1; RegList = 16'($urandom); Rn = 4'($urandom); BaseAddr = $urandom;
                end
            end
        end
        Start = 1'b0;
        MemValid = 1'b0;
        if (!aborted) begin
            if (!done_seen) begin
                tests++;
                fails++;
                $display("FAIL timeout: got no Done within 300 cycles, expected Done for list %0h", list);
            end
            @(posedge CLK); #1;
            check("events_drained", exp_q.size(), 0);
            check("addrs_drained", addr_exp.size(), 0);
        end
    endtask

    initial begin
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs_zero",
              {MemAddr, MemReady, A3, WD3, WE3, PCWrite, PCData, Busy, Done}, 0);
        RESET = 1'b1;

        fill_words(); words[0] = 32'hAA; words[1] = 32'hBB;
        run_op(16'h0006, 4'd1, 32'h100, 0, 1'b1, 0, 1'b0);

        fill_words();
        run_op(16'h0000, 4'd0, 32'h200, 0, 1'b1, 0, 1'b0);

        fill_words(); words[0] = 32'h11; words[1] = 32'h2000;
        run_op(16'h8001, 4'd15, 32'h300, 0, 1'b1, 0, 1'b0);

        fill_words(); words[0] = 32'h55;
        run_op(16'h0010, 4'd4, 32'h400, 3, 1'b1, 0, 1'b0);

        fill_words();
        run_op(16'h00F0, 4'd2, 32'h500, 0, 1'b1, 2, 1'b0);

        fill_words(); words[0] = 32'hAA; words[1] = 32'hBB;
        run_op(16'h0006, 4'd1, 32'h100, 0, 1'b1, 0, 1'b0);

        fill_words();
        run_op(16'h0003, 4'd13, 32'h40, 0, 1'b1, 0, 1'b0);
        fill_words();
        run_op(16'h0003, 4'd1, 32'h40, 0, 1'b1, 0, 1'b0);

        fill_words();
        run_op(16'h000F, 4'd5, 32'hFFFF_FFF8, 0, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] l;
            fill_words();
            case ($urandom_range(0, 4))
                0:       l = 16'd1 << $urandom_range(0, 15);
                1:       l = 16'd0;
                default: l = 16'($urandom);
            endcase
            run_op(l, 4'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 0,
                   1'($urandom_range(0, 1)), 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
